// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_WIN   = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  // Per-channel configuration held in both shadow and active copies.
  typedef struct packed {
    logic [1:0]           mode;
    logic [CNT_W_DEF-1:0] cmp1;
    logic [CNT_W_DEF-1:0] cmp2;
    logic                 inv;
  } pwm_ch_cfg_t;

endpackage

// File: rtl/pwm_multi_gen_if.sv
// Configuration and output bundle between the register file and the PWM block.
interface pwm_multi_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PSC_W  = 8
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              en;
  logic [CNT_W-1:0]  period;
  logic [PSC_W-1:0]  prescale;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_cmp1;
  logic [CNT_W-1:0]  cfg_cmp2;
  logic              cfg_inv;
  logic [CNT_W-1:0]  count_val;
  logic              period_tick;
  logic [NUM_CH-1:0] pwm_out;

  modport master (
    output en, period, prescale, cfg_we, cfg_ch, cfg_mode, cfg_cmp1, cfg_cmp2, cfg_inv,
    input  count_val, period_tick, pwm_out
  );

  modport slave (
    input  en, period, prescale, cfg_we, cfg_ch, cfg_mode, cfg_cmp1, cfg_cmp2, cfg_inv,
    output count_val, period_tick, pwm_out
  );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active config, compare against the shared counter, output flop.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic                 i_we,
  input  pwm_ch_cfg_t          i_cfg,
  input  logic [CNT_W_DEF-1:0] i_cnt,
  output logic                 o_pwm
);

  pwm_ch_cfg_t r_shadow;
  pwm_ch_cfg_t r_active;
  pwm_ch_cfg_t w_next_active;
  logic        w_raw;

  // A write landing on a load cycle bypasses the shadow straight into active.
  always_comb w_next_active = i_we ? i_cfg : r_shadow;

  always_comb begin
    w_raw = 1'b0;
    case (r_active.mode)
      MODE_LEFT:  w_raw = (i_cnt < r_active.cmp1);
      MODE_RIGHT: w_raw = (i_cnt >= r_active.cmp1);
      MODE_WIN:   w_raw = (i_cnt >= r_active.cmp1) && (i_cnt < r_active.cmp2);
      default:    w_raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      o_pwm    <= 1'b0;
    end else begin
      if (i_we)   r_shadow <= i_cfg;
      if (i_load) r_active <= w_next_active;
      o_pwm <= i_en & (w_raw ^ r_active.inv);
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaled timebase feeding NUM_CH channels.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PSC_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  pwm_multi_gen_if.slave  bus
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PSC_W-1:0]  r_psc;
  logic [PSC_W-1:0]  r_act_prescale;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_act_period;
  logic              r_period_tick;
  logic              w_tick;
  logic              w_wrap;
  logic              w_load;
  logic [NUM_CH-1:0] w_pwm;
  pwm_ch_cfg_t       w_cfg;

  assign w_tick = (r_psc == r_act_prescale);
  assign w_wrap = bus.en & w_tick & (r_cnt == r_act_period);
  // While disabled, active registers track shadow/inputs every cycle.
  assign w_load = ~bus.en | w_wrap;

  assign w_cfg = '{mode: bus.cfg_mode, cmp1: bus.cfg_cmp1, cmp2: bus.cfg_cmp2, inv: bus.cfg_inv};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc          <= '0;
      r_cnt          <= '0;
      r_act_period   <= '0;
      r_act_prescale <= '0;
      r_period_tick  <= 1'b0;
    end else if (!bus.en) begin
      r_psc          <= '0;
      r_cnt          <= '0;
      r_act_period   <= bus.period;
      r_act_prescale <= bus.prescale;
      r_period_tick  <= 1'b0;
    end else begin
      r_period_tick <= w_wrap;
      if (w_tick) begin
        r_psc <= '0;
        r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      end else begin
        r_psc <= r_psc + PSC_W'(1);
      end
      // Period and prescale only change at wrap, so cnt never exceeds act_period.
      if (w_wrap) begin
        r_act_period   <= bus.period;
        r_act_prescale <= bus.prescale;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_we;
    assign w_we = bus.cfg_we & (bus.cfg_ch == CH_W'(i));

    pwm_channel u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_en   (bus.en),
      .i_load (w_load),
      .i_we   (w_we),
      .i_cfg  (w_cfg),
      .i_cnt  (r_cnt),
      .o_pwm  (w_pwm[i])
    );
  end

  assign bus.count_val   = r_cnt;
  assign bus.period_tick = r_period_tick;
  assign bus.pwm_out     = w_pwm;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed self-checking bench for pwm_multi_gen (3 channels so an out-of-range cfg_ch exists).
module tb_pwm_multi_gen;
  import pwm_pkg::*;

  localparam int unsigned NCH = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [15:0] exp_cnt;
  logic        exp_tick;
  logic        exp_pwm;

  always #5 clk = ~clk;

  pwm_multi_gen_if #(.NUM_CH(NCH), .CNT_W(16), .PSC_W(8)) bus();

  pwm_multi_gen #(.NUM_CH(NCH), .CNT_W(16), .PSC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired: got no finish want finish");
    $fatal(1);
  end

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [15:0] c1, input logic [15:0] c2, input logic inv);
    bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_mode = mode;
    bus.cfg_cmp1 = c1; bus.cfg_cmp2 = c2; bus.cfg_inv = inv;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic idle_cfg(input logic [15:0] per, input logic [7:0] psc);
    bus.en = 1'b0; bus.period = per; bus.prescale = psc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.period = '0; bus.prescale = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_mode = '0;
    bus.cfg_cmp1 = '0; bus.cfg_cmp2 = '0; bus.cfg_inv = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.count_val !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bus.count_val); end
    n_cmp++;
    if (bus.period_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %0b want 0", bus.period_tick); end
    n_cmp++;
    if (bus.pwm_out !== 3'b000) begin n_err++; $display("FAIL reset_pwm got %b want 000", bus.pwm_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_left_basic();
    int hi = 0;
    idle_cfg(16'd9, 8'd0);
    cfg_write(2'd0, MODE_LEFT, 16'd3, 16'd0, 1'b0);
    bus.en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_cnt = 16'(k % 10); exp_tick = (exp_cnt == 16'd0); exp_pwm = ((k - 1) % 10) < 3;
      n_cmp++;
      if ({bus.count_val, bus.period_tick, bus.pwm_out[0]} !== {exp_cnt, exp_tick, exp_pwm}) begin
        n_err++;
        $display("FAIL left_basic k=%0d got cnt=%0d tick=%0b pwm=%0b want cnt=%0d tick=%0b pwm=%0b",
                 k, bus.count_val, bus.period_tick, bus.pwm_out[0], exp_cnt, exp_tick, exp_pwm);
      end
      if (k > 10 && k <= 20) hi += int'(bus.pwm_out[0]);
    end
    n_cmp++;
    if (hi !== 3) begin n_err++; $display("FAIL left_duty got %0d want 3", hi); end
  endtask

  task automatic test_prescaler();
    idle_cfg(16'd4, 8'd2);
    bus.en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      exp_cnt = 16'((k / 3) % 5); exp_tick = (k % 15 == 0); exp_pwm = (((k - 1) / 3) % 5) < 3;
      n_cmp++;
      if ({bus.count_val, bus.period_tick, bus.pwm_out[0]} !== {exp_cnt, exp_tick, exp_pwm}) begin
        n_err++;
        $display("FAIL prescaler k=%0d got cnt=%0d tick=%0b pwm=%0b want cnt=%0d tick=%0b pwm=%0b",
                 k, bus.count_val, bus.period_tick, bus.pwm_out[0], exp_cnt, exp_tick, exp_pwm);
      end
    end
  endtask

  task automatic test_window_invert();
    int c;
    idle_cfg(16'd9, 8'd0);
    cfg_write(2'd1, MODE_WIN, 16'd2, 16'd6, 1'b1);
    n_cmp++;
    if (bus.pwm_out[1] !== 1'b0) begin n_err++; $display("FAIL win_disabled got %0b want 0", bus.pwm_out[1]); end
    bus.en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      c = (k - 1) % 10;
      exp_pwm = !(c >= 2 && c < 6);
      n_cmp++;
      if (bus.pwm_out[1] !== exp_pwm) begin
        n_err++; $display("FAIL window_inv k=%0d got %0b want %0b", k, bus.pwm_out[1], exp_pwm);
      end
    end
    idle_cfg(16'd9, 8'd0);
    cfg_write(2'd1, MODE_WIN, 16'd6, 16'd2, 1'b1);
    bus.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.pwm_out[1] !== 1'b1) begin
        n_err++; $display("FAIL window_empty_inv k=%0d got %0b want 1", k, bus.pwm_out[1]);
      end
    end
  endtask

  task automatic test_glitch_free();
    logic [15:0] cmp;
    idle_cfg(16'd9, 8'd0);
    cfg_write(2'd0, MODE_LEFT, 16'd3, 16'd0, 1'b0);
    bus.en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      cmp = (k <= 10) ? 16'd3 : (k <= 20) ? 16'd7 : 16'd5;
      exp_cnt = 16'(k % 10); exp_tick = (exp_cnt == 16'd0);
      exp_pwm = 16'((k - 1) % 10) < cmp;
      n_cmp++;
      if ({bus.count_val, bus.period_tick, bus.pwm_out[0]} !== {exp_cnt, exp_tick, exp_pwm}) begin
        n_err++;
        $display("FAIL glitch_free k=%0d got cnt=%0d tick=%0b pwm=%0b want cnt=%0d tick=%0b pwm=%0b",
                 k, bus.count_val, bus.period_tick, bus.pwm_out[0], exp_cnt, exp_tick, exp_pwm);
      end
      // mid-period write at cnt=4, then a write on the wrap edge (cnt=9)
      if (k == 4 || k == 19) begin
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_mode = MODE_LEFT;
        bus.cfg_cmp1 = (k == 4) ? 16'd7 : 16'd5; bus.cfg_cmp2 = '0; bus.cfg_inv = 1'b0;
      end else begin
        bus.cfg_we = 1'b0;
      end
    end
  endtask

  task automatic test_boundaries();
    idle_cfg(16'd9, 8'd0);
    cfg_write(2'd0, MODE_LEFT,  16'd0,  16'd0, 1'b0);
    cfg_write(2'd1, MODE_RIGHT, 16'd0,  16'd0, 1'b0);
    cfg_write(2'd2, MODE_LEFT,  16'd20, 16'd0, 1'b0);
    bus.en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.pwm_out !== 3'b110) begin n_err++; $display("FAIL bound_cmp k=%0d got %b want 110", k, bus.pwm_out); end
    end
    for (int w = 0; w < 2; w++) begin
      idle_cfg(16'd9, 8'd0);
      if (w == 0) cfg_write(2'd3, MODE_OFF,  16'd0, 16'd0, 1'b0);
      else        cfg_write(2'd3, MODE_LEFT, 16'd0, 16'd0, 1'b1);
      bus.en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        n_cmp++;
        if (bus.pwm_out !== 3'b110) begin
          n_err++; $display("FAIL bad_ch w=%0d k=%0d got %b want 110", w, k, bus.pwm_out);
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      idle_cfg(16'd0, 8'(p));
      bus.en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        exp_tick = (p == 0) ? 1'b1 : (k % 2 == 0);
        n_cmp++;
        if ({bus.count_val, bus.period_tick} !== {16'd0, exp_tick}) begin
          n_err++;
          $display("FAIL period0 psc=%0d k=%0d got cnt=%0d tick=%0b want cnt=0 tick=%0b",
                   p, k, bus.count_val, bus.period_tick, exp_tick);
        end
      end
    end
  endtask

  task automatic test_enable_reset();
    idle_cfg(16'd9, 8'd0);
    cfg_write(2'd0, MODE_LEFT, 16'd3, 16'd0, 1'b1);
    bus.en = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.count_val !== 16'd5) begin n_err++; $display("FAIL en_pre got %0d want 5", bus.count_val); end
    bus.en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.count_val, bus.period_tick, bus.pwm_out} !== {16'd0, 1'b0, 3'b000}) begin
      n_err++; $display("FAIL en_drop got cnt=%0d tick=%0b pwm=%b want cnt=0 tick=0 pwm=000",
                        bus.count_val, bus.period_tick, bus.pwm_out);
    end
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.count_val, bus.period_tick, bus.pwm_out} !== {16'd0, 1'b0, 3'b000}) begin
      n_err++; $display("FAIL mid_reset got cnt=%0d tick=%0b pwm=%b want cnt=0 tick=0 pwm=000",
                        bus.count_val, bus.period_tick, bus.pwm_out);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_cnt = 16'((k - 1) % 10); exp_tick = (exp_cnt == 16'd0);
      n_cmp++;
      if ({bus.count_val, bus.period_tick, bus.pwm_out} !== {exp_cnt, exp_tick, 3'b000}) begin
        n_err++;
        $display("FAIL post_reset k=%0d got cnt=%0d tick=%0b pwm=%b want cnt=%0d tick=%0b pwm=000",
                 k, bus.count_val, bus.period_tick, bus.pwm_out, exp_cnt, exp_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_basic();
    test_prescaler();
    test_window_invert();
    test_glitch_free();
    test_boundaries();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
